// File: rtl/kyber_decomp_ctrl.sv
// Sequencer for decompressing one Kyber polynomial: streams N compressed coefficients
// from source memory through an external decompress unit into destination memory.
module kyber_decomp_ctrl #(
    parameter int D       = 10,
    parameter int DEC_LAT = 1,
    parameter int N       = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          src_rd_en,
    output logic [7:0]    src_addr,
    input  logic [D-1:0]  src_data,
    output logic [D-1:0]  dec_in,
    input  logic [11:0]   dec_out,
    output logic          dst_we,
    output logic [7:0]    dst_addr,
    output logic [11:0]   dst_data
);

    localparam int STAGES = 1 + DEC_LAT;
    localparam logic [7:0] LAST_IDX = 8'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          rd_cnt_q, rd_cnt_d;
    logic [STAGES-1:0]   vld_q, vld_d;
    logic [7:0]          idx_q [STAGES];
    logic [7:0]          idx_d [STAGES];
    logic [7:0]          dst_addr_q, dst_addr_d;
    logic [11:0]         dst_data_q, dst_data_d;

    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    rd_cnt_d = 8'd0;
                end
            end
            RUN: begin
                // The counter parks on the last index so src_addr holds through DRAIN.
                if (rd_cnt_q == LAST_IDX) state_d = DRAIN;
                else                      rd_cnt_d = rd_cnt_q + 8'd1;
            end
            DRAIN: begin
                if (dst_we && (idx_q[STAGES-1] == LAST_IDX)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        src_rd_en = (state_q == RUN);
        src_addr  = rd_cnt_q;
        busy      = (state_q == RUN) || (state_q == DRAIN);
        done      = (state_q == DONE);
        dec_in    = src_data;
    end

    // Stage 0 lines up with the cycle read data returns; the last stage with dec_out.
    always_comb begin
        vld_d    = {vld_q[STAGES-2:0], src_rd_en};
        idx_d[0] = src_addr;
        for (int i = 1; i < STAGES; i++) begin
            idx_d[i] = idx_q[i-1];
        end
    end

    always_comb begin
        dst_we     = vld_q[STAGES-1];
        dst_addr   = dst_we ? idx_q[STAGES-1] : dst_addr_q;
        dst_data   = dst_we ? dec_out : dst_data_q;
        dst_addr_d = dst_addr;
        dst_data_d = dst_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_cnt_q   <= 8'd0;
            vld_q      <= '0;
            dst_addr_q <= 8'd0;
            dst_data_q <= 12'd0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            vld_q      <= vld_d;
            dst_addr_q <= dst_addr_d;
            dst_data_q <= dst_data_d;
        end
    end

    // Index pipeline is qualified by vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            idx_q[i] <= idx_d[i];
        end
    end

endmodule

// File: tb/tb_kyber_decomp_ctrl.sv
// Bench for kyber_decomp_ctrl: three configurations (D/DEC_LAT = 10/1, 4/3, 1/2) with
// source-memory and decompress-unit models, scoreboarded writes and timing checks.
module tb_kyber_decomp_ctrl;

    localparam int N = 256;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn  [3];
    logic        start [3];
    logic        busy  [3];
    logic        done  [3];
    logic        srd   [3];
    logic [7:0]  saddr [3];
    logic        we    [3];
    logic [7:0]  daddr [3];
    logic [11:0] ddata [3];

    typedef struct packed {
        logic [7:0]  addr;
        logic [11:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [11:0] cap [3][N];

    function automatic logic [11:0] decomp(input int d, input int x);
        return 12'((3329 * x + (1 << (d - 1))) >> d);
    endfunction

    function automatic int dparam(input int g);
        return (g == 0) ? 10 : (g == 1) ? 4 : 1;
    endfunction

    function automatic int lparam(input int g);
        return (g == 0) ? 1 : (g == 1) ? 3 : 2;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DG = (g == 0) ? 10 : (g == 1) ? 4 : 1;
        localparam int LG = (g == 0) ? 1 : (g == 1) ? 3 : 2;

        logic [DG-1:0] sdata = '0;
        logic [DG-1:0] din;
        logic [11:0]   pipe [LG];

        // Source memory holds src[k] = k mod 2^D; data returns one cycle after the strobe.
        always @(posedge clk) begin
            if (srd[g]) sdata <= DG'(int'(saddr[g]) % (1 << DG));
        end

        always @(posedge clk) begin
            pipe[0] <= decomp(DG, int'(din));
            for (int j = 1; j < LG; j++) pipe[j] <= pipe[j-1];
        end

        kyber_decomp_ctrl #(.D(DG), .DEC_LAT(LG), .N(N)) u_dut (
            .clk       (clk),
            .rst_n     (rstn[g]),
            .start     (start[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .src_rd_en (srd[g]),
            .src_addr  (saddr[g]),
            .src_data  (sdata),
            .dec_in    (din),
            .dec_out   (pipe[LG-1]),
            .dst_we    (we[g]),
            .dst_addr  (daddr[g]),
            .dst_data  (ddata[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_job(input int g, input bit hold);
        int   l, d, cyc, nrd, nwr, first_wr, last_wr, done_cyc, ndone, busy_err, addr_err;
        exp_t e;
        l = lparam(g); d = dparam(g);
        nrd = 0; nwr = 0; first_wr = -1; last_wr = -1; done_cyc = -1;
        ndone = 0; busy_err = 0; addr_err = 0;
        sb.delete();
        @(posedge clk); #1 start[g] = 1'b1;
        @(posedge clk); #1 if (!hold) start[g] = 1'b0;
        cyc = 1;
        while (cyc <= N + 3 + l) begin
            @(negedge clk);
            if (busy[g] !== ((cyc >= 1) && (cyc <= N + 1 + l))) busy_err++;
            if (srd[g]) begin
                if (saddr[g] !== 8'(nrd)) addr_err++;
                e.addr = 8'(nrd);
                e.data = decomp(d, nrd % (1 << d));
                sb.push_back(e);
                nrd++;
            end
            if (we[g]) begin
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                nwr++;
                if (sb.size() == 0) begin
                    check($sformatf("g%0d_sb_underflow", g), sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("g%0d_wr_addr", g), daddr[g], e.addr);
                    check($sformatf("g%0d_wr_data", g), ddata[g], e.data);
                    cap[g][daddr[g]] = ddata[g];
                end
            end
            if (done[g]) begin
                ndone++;
                done_cyc = cyc;
            end
            @(posedge clk);
            cyc++;
        end
        check($sformatf("g%0d_nreads", g), nrd, N);
        check($sformatf("g%0d_nwrites", g), nwr, N);
        check($sformatf("g%0d_first_wr", g), first_wr, 2 + l);
        check($sformatf("g%0d_last_wr", g), last_wr, N + 1 + l);
        check($sformatf("g%0d_done_cyc", g), done_cyc, N + 2 + l);
        check($sformatf("g%0d_done_pulses", g), ndone, 1);
        check($sformatf("g%0d_busy_window", g), busy_err, 0);
        check($sformatf("g%0d_src_addr_seq", g), addr_err, 0);
        check($sformatf("g%0d_sb_left", g), sb.size(), 0);
    endtask

    task automatic wait_done(input int g, input int max_cyc);
        bit found;
        found = 1'b0;
        for (int c = 0; c < max_cyc && !found; c++) begin
            @(negedge clk);
            if (done[g]) found = 1'b1;
        end
        check($sformatf("g%0d_done_seen", g), found, 1);
    endtask

    task automatic reset_test();
        int cyc, nz, post_we;
        bit hit;
        cyc = 0; nz = 0; post_we = 0; hit = 1'b0;
        @(posedge clk); #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        while (!hit && cyc < 400) begin
            @(negedge clk);
            if (we[0] && daddr[0] == 8'd100) hit = 1'b1;
            else begin
                @(posedge clk);
                cyc++;
            end
        end
        check("rst_reached_wr100", hit, 1);
        rstn[0] = 1'b0;
        #1;
        check("rst_busy", busy[0], 0);
        check("rst_done", done[0], 0);
        check("rst_src_rd_en", srd[0], 0);
        check("rst_dst_we", we[0], 0);
        check("rst_src_addr", saddr[0], 0);
        check("rst_dst_addr", daddr[0], 0);
        check("rst_dst_data", ddata[0], 0);
        repeat (2) begin
            @(posedge clk);
            #1 if (we[0] || busy[0] || srd[0]) nz++;
        end
        check("rst_held_quiet", nz, 0);
        @(negedge clk);
        rstn[0] = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (we[0]) post_we++;
        end
        check("rst_no_writes_after", post_we, 0);
    endtask

    initial begin
        int hold_err;
        for (int g = 0; g < 3; g++) begin
            rstn[g]  = 1'b0;
            start[g] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("g%0d_reset_busy", g), busy[g], 0);
            check($sformatf("g%0d_reset_done", g), done[g], 0);
            check($sformatf("g%0d_reset_we", g), we[g], 0);
            check($sformatf("g%0d_reset_srd", g), srd[g], 0);
            check($sformatf("g%0d_reset_saddr", g), saddr[g], 0);
            check($sformatf("g%0d_reset_daddr", g), daddr[g], 0);
            check($sformatf("g%0d_reset_ddata", g), ddata[g], 0);
        end
        @(negedge clk);
        for (int g = 0; g < 3; g++) rstn[g] = 1'b1;

        // D=10, DEC_LAT=1: src[k]=k
        run_job(0, 1'b0);
        check("g0_dst1", cap[0][1], 3);
        check("g0_dst255", cap[0][255], 829);
        repeat (3) @(negedge clk);
        check("g0_hold_we", we[0], 0);
        check("g0_hold_daddr", daddr[0], 255);
        check("g0_hold_ddata", ddata[0], 829);
        check("g0_hold_saddr", saddr[0], 255);

        // D=4, DEC_LAT=3: src[k]=k mod 16
        run_job(1, 1'b0);
        check("g1_dst1", cap[1][1], 208);
        check("g1_dst15", cap[1][15], 3121);
        check("g1_dst16", cap[1][16], 0);

        // D=1, DEC_LAT=2: alternating 0,1
        run_job(2, 1'b0);
        check("g2_dst0", cap[2][0], 0);
        check("g2_dst1", cap[2][1], 1665);
        check("g2_dst255", cap[2][255], 1665);

        // start held high for 300 cycles: second job only after done
        run_job(0, 1'b1);
        hold_err = 0;
        repeat (39) begin
            @(negedge clk);
            if (busy[0] !== 1'b1 || done[0] !== 1'b0) hold_err++;
            @(posedge clk);
        end
        #1 start[0] = 1'b0;
        check("hold_second_job_busy", hold_err, 0);
        wait_done(0, 400);
        hold_err = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy[0] !== 1'b0 || done[0] !== 1'b0) hold_err++;
        end
        check("hold_no_third_job", hold_err, 0);

        // reset mid-job, then a fresh full job
        reset_test();
        run_job(0, 1'b0);
        check("g0_after_rst_dst1", cap[0][1], 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
